// File: rtl/instr_mem_prog.sv
// Loadable instruction memory: streamed program load, then 1-cycle registered fetch.
module instr_mem_prog #(
  parameter int unsigned                DATA_WIDTH = 32,
  parameter int unsigned                ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0]      NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic                  addr_fault,
  output logic [ADDR_WIDTH:0]   prog_len,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LEN_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wp;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_start;
  logic w_accept;
  logic w_full;
  logic w_fetch;
  logic w_in_range;

  // Qualified events: load start, accepted beat, last slot, fetch honoured
  assign w_start    = (r_state != S_LOAD) && ld_start;
  assign w_accept   = (r_state == S_LOAD) && ld_valid;
  assign w_full     = (r_wp == {ADDR_WIDTH{1'b1}});
  assign w_fetch    = (r_state == S_RUN) && fetch_en && !ld_start;
  assign w_in_range = (LEN_W'(fetch_addr) < prog_len);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (ld_start) w_state_nxt = S_LOAD;
      S_LOAD: if (w_accept && (ld_last || w_full)) w_state_nxt = S_RUN;
      S_RUN:  if (ld_start) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ld_ready = 1'b0;
    busy     = 1'b0;
    if (r_state == S_LOAD) begin
      ld_ready = 1'b1;
      busy     = 1'b1;
    end
  end

  // Write pointer and program length; the pointer stops at the last slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp     <= '0;
      prog_len <= '0;
    end else if (w_start) begin
      r_wp     <= '0;
      prog_len <= '0;
    end else if (w_accept) begin
      if (!w_full) r_wp <= r_wp + ADDR_WIDTH'(1);
      prog_len <= prog_len + LEN_W'(1);
    end
  end

  // Memory array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wp] <= ld_data;
    end
  end

  // Registered fetch response; instr and addr_fault hold when no fetch is honoured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
    end else begin
      instr_valid <= w_fetch;
      if (w_fetch) begin
        if (w_in_range) begin
          instr      <= r_mem[fetch_addr];
          addr_fault <= 1'b0;
        end else begin
          instr      <= NOP_WORD;
          addr_fault <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_prog.sv
// Scoreboard bench for instr_mem_prog: reference model pushes expected fetch responses,
// a negedge monitor pops and compares them, and checks hold behaviour otherwise.
module tb_instr_mem_prog;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [DW-1:0] NOP = 32'hA5A5_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic          fetch_en = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          addr_fault;
  logic [AW:0]   prog_len;
  logic          busy;

  instr_mem_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .instr(instr), .instr_valid(instr_valid), .addr_fault(addr_fault),
    .prog_len(prog_len), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [DW-1:0] instr;
    bit          fault;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: a program is a list of words; mode is idle / loading / running
  typedef enum int { M_IDLE, M_LOAD, M_RUN } mode_t;
  mode_t         m_mode = M_IDLE;
  int            m_len  = 0;
  logic [DW-1:0] m_mem [DEPTH];

  logic [DW-1:0] last_instr = NOP;
  bit            last_fault = 1'b0;

  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: a due response must appear now; otherwise no valid and outputs held
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("resp_valid", 64'(instr_valid), 64'd1);
        chk("resp_instr", 64'(instr), 64'(e.instr));
        chk("resp_fault", 64'(addr_fault), 64'(e.fault));
        last_instr = e.instr;
        last_fault = e.fault;
      end else begin
        chk("idle_valid", 64'(instr_valid), 64'd0);
        chk("hold_instr", 64'(instr), 64'(last_instr));
        chk("hold_fault", 64'(addr_fault), 64'(last_fault));
      end
    end
  end

  // Apply one cycle of inputs, advance the model, check the control outputs after the edge
  task automatic drive(input bit s, input bit v, input logic [DW-1:0] d, input bit l,
                       input bit f, input logic [AW-1:0] a);
    exp_t e;
    ld_start = s; ld_valid = v; ld_data = d; ld_last = l;
    fetch_en = f; fetch_addr = a;
    if (m_mode == M_RUN && f && !s) begin
      e.due   = cyc + 1;
      e.fault = (int'(a) >= m_len);
      e.instr = e.fault ? NOP : m_mem[a];
      q.push_back(e);
    end
    if (m_mode != M_LOAD && s) begin
      m_mode = M_LOAD;
      m_len  = 0;
    end else if (m_mode == M_LOAD && v) begin
      m_mem[m_len] = d;
      m_len++;
      if (l || m_len == DEPTH) m_mode = M_RUN;
    end
    @(posedge clk);
    #1;
    chk("prog_len", 64'(prog_len), 64'(m_len));
    chk("busy", 64'(busy), 64'(m_mode == M_LOAD));
    chk("ld_ready", 64'(ld_ready), 64'(m_mode == M_LOAD));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    ld_start = 0; ld_valid = 0; ld_last = 0; fetch_en = 0;
    #1;
    chk("rst_instr", 64'(instr), 64'(NOP));
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_fault", 64'(addr_fault), 64'd0);
    chk("rst_len", 64'(prog_len), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ld_ready), 64'd0);
    q.delete();
    m_mode = M_IDLE;
    m_len  = 0;
    last_instr = NOP;
    last_fault = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Basic four-word program with explicit last
    drive(1, 0, '0, 0, 0, '0);
    drive(0, 1, 32'h11, 0, 0, '0);
    drive(0, 1, 32'h22, 0, 1, 3'd1);
    drive(0, 0, 32'h99, 0, 0, '0);
    drive(0, 1, 32'h33, 0, 0, '0);
    drive(0, 1, 32'h44, 1, 0, '0);
    chk("len_after_load", 64'(prog_len), 64'd4);
    // Back-to-back in-range fetches, then out-of-range, then stalls
    drive(0, 0, '0, 0, 1, 3'd2);
    drive(0, 0, '0, 0, 1, 3'd3);
    drive(0, 0, '0, 0, 1, 3'd4);
    drive(0, 0, '0, 0, 0, 3'd0);
    drive(0, 1, 32'h55, 1, 0, 3'd0);
    drive(0, 0, '0, 0, 1, 3'd0);

    // ld_start and fetch in the same RUN cycle: fetch dropped
    drive(1, 0, '0, 0, 1, 3'd0);
    chk("restart_busy", 64'(busy), 64'd1);

    // Fill to depth without last; extra beat is not accepted
    for (int i = 0; i < int'(DEPTH); i++) drive(0, 1, 32'h1000 + 32'(i), 0, 0, '0);
    chk("full_len", 64'(prog_len), 64'(DEPTH));
    drive(0, 1, 32'hBAD0_0000, 0, 0, '0);
    drive(0, 0, '0, 0, 1, 3'd0);
    drive(0, 0, '0, 0, 1, 3'd7);
    drive(0, 0, '0, 0, 0, 3'd0);

    // Reset in the middle of a load
    drive(1, 0, '0, 0, 0, '0);
    drive(0, 1, 32'hAB, 0, 0, '0);
    drive(0, 1, 32'hCD, 0, 0, '0);
    do_reset();
    drive(0, 0, '0, 0, 1, 3'd0);
    drive(0, 1, 32'hEE, 1, 1, 3'd1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)), $urandom,
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
            AW'($urandom_range(0, DEPTH - 1)));
    end

    // Drain
    for (int n = 0; n < 3; n++) drive(0, 0, '0, 0, 0, '0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
